// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Bit position of each requester in the arbiter request/grant vectors.
  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester was not granted last.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves gnt unassigned (no latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the core and the debug/loader port,
// one transaction at a time, with a per-transaction timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_ack,
  output logic              o_core_err,
  output logic [DATA_W-1:0] o_core_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic              o_dbg_err,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state;
  req_id_e            last_grant;
  req_id_e            owner;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               mem_req_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               core_ack_q, dbg_ack_q;
  logic               core_err_q, dbg_err_q;
  logic [DATA_W-1:0]  core_rdata_q, dbg_rdata_q;

  logic [1:0]         gnt;
  logic               expire;
  logic               done;
  logic               done_err;
  logic               load_rdata;
  logic [DATA_W-1:0]  rdata_nxt;

  rr_arbiter_2 u_rr (
    .req        ({i_dbg_req, i_core_req}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // The counter would reach TIMEOUT on this edge, so this is the last cycle allowed.
  assign expire = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Completion is decided one cycle ahead of the ack; ready/rvalid beat expiry.
  always_comb begin
    done     = 1'b0;
    done_err = 1'b0;
    case (state)
      REQ: begin
        if (i_mem_ready) begin
          done = we_q;
        end else if (expire) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          done = 1'b1;
        end else if (expire) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign load_rdata = done & (done_err | ~we_q);
  assign rdata_nxt  = done_err ? '0 : i_mem_rdata;

  // NOTE: address/data registers are reset too, since they drive o_mem_* directly.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      last_grant <= REQ_DBG;
      owner      <= REQ_CORE;
      tmo_cnt    <= '0;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner      <= gnt[1] ? REQ_DBG : REQ_CORE;
            last_grant <= gnt[1] ? REQ_DBG : REQ_CORE;
            we_q       <= gnt[1] ? i_dbg_we    : i_core_we;
            addr_q     <= gnt[1] ? i_dbg_addr  : i_core_addr;
            wdata_q    <= gnt[1] ? i_dbg_wdata : i_core_wdata;
            mem_req_q  <= 1'b1;
            tmo_cnt    <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (i_mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= we_q ? RESP : WAIT;
          end else if (expire) begin
            mem_req_q <= 1'b0;
            state     <= RESP;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (i_mem_rvalid || expire) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only the owner's response registers move; the other side keeps its values.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      core_err_q   <= 1'b0;
      dbg_err_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      core_ack_q <= done && (owner == REQ_CORE);
      dbg_ack_q  <= done && (owner == REQ_DBG);
      if (done && (owner == REQ_CORE)) begin
        core_err_q <= done_err;
        if (load_rdata) core_rdata_q <= rdata_nxt;
      end
      if (done && (owner == REQ_DBG)) begin
        dbg_err_q <= done_err;
        if (load_rdata) dbg_rdata_q <= rdata_nxt;
      end
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_core_ack   = core_ack_q;
  assign o_core_err   = core_err_q;
  assign o_core_rdata = core_rdata_q;
  assign o_dbg_ack    = dbg_ack_q;
  assign o_dbg_err    = dbg_err_q;
  assign o_dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected memory
// accesses and responses, monitors pop and compare them as the DUT presents them.
module tb_mem_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct packed {
    logic        dbg;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk, arstn;
  logic        i_core_req, i_core_we, i_dbg_req, i_dbg_we;
  logic [31:0] i_core_addr, i_core_wdata, i_dbg_addr, i_dbg_wdata;
  logic        o_core_ack, o_core_err, o_dbg_ack, o_dbg_err;
  logic [31:0] o_core_rdata, o_dbg_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  mem_t        mem_q[$];
  rsp_t        rsp_q[$];

  int          ready_dly;
  int          rv_dly;
  logic [31:0] rv_data;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_core_req   (i_core_req),
    .i_core_we    (i_core_we),
    .i_core_addr  (i_core_addr),
    .i_core_wdata (i_core_wdata),
    .o_core_ack   (o_core_ack),
    .o_core_err   (o_core_err),
    .o_core_rdata (o_core_rdata),
    .i_dbg_req    (i_dbg_req),
    .i_dbg_we     (i_dbg_we),
    .i_dbg_addr   (i_dbg_addr),
    .i_dbg_wdata  (i_dbg_wdata),
    .o_dbg_ack    (o_dbg_ack),
    .o_dbg_err    (o_dbg_err),
    .o_dbg_rdata  (o_dbg_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  task automatic exp_rsp(input logic dbg, input logic err, input logic rd, input logic [31:0] rdata);
    rsp_t r;
    r.dbg = dbg; r.err = err; r.rd = rd; r.rdata = rdata;
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic dbg, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (dbg) begin
      i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_addr = addr; i_dbg_wdata = wdata;
    end else begin
      i_core_req = 1'b1; i_core_we = we; i_core_addr = addr; i_core_wdata = wdata;
    end
  endtask

  // Waits for n_acks acknowledges, drops every request in the last ack cycle,
  // and checks the cycle count (negedges since the call) of that last ack.
  task automatic wait_acks(input string name, input int n_acks, input int exp_lat, output int req_cycles);
    int n;
    int seen;
    n = 0; seen = 0; req_cycles = 0;
    while (seen < n_acks && n < exp_lat + 4 * TMO + 20) begin
      @(negedge clk);
      n++;
      if (o_mem_req) req_cycles++;
      if (o_core_ack || o_dbg_ack) begin
        seen++;
        if (seen == n_acks) begin
          i_core_req = 1'b0;
          i_dbg_req  = 1'b0;
        end
      end
    end
    check({name, "_acks"}, 96'(seen), 96'(n_acks));
    check({name, "_latency"}, 96'(n), 96'(exp_lat));
  endtask

  // Memory model: ready after ready_dly cycles of o_mem_req (-1 = never),
  // rvalid rv_dly cycles after the accepting cycle of a read (-1 = never).
  initial begin
    int req_cnt;
    int rv_left;
    req_cnt = 0; rv_left = -1;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0BAD_F00D;
      if (!arstn) begin
        req_cnt = 0;
        rv_left = -1;
      end else begin
        if (rv_left > 0) begin
          rv_left--;
          if (rv_left == 0) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rv_data;
            rv_left      = -1;
          end
        end
        if (o_mem_req) begin
          if (ready_dly >= 0 && req_cnt == ready_dly) begin
            i_mem_ready = 1'b1;
            if (!o_mem_we && rv_dly > 0) rv_left = rv_dly;
          end
          req_cnt++;
        end else begin
          req_cnt = 0;
        end
      end
    end
  end

  // Monitors: every accepted memory request and every ack is matched in order.
  initial begin
    mem_t        m;
    rsp_t        r;
    logic        act_err;
    logic [31:0] act_rdata;
    forever begin
      @(negedge clk);
      if (o_mem_req && i_mem_ready) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", {o_mem_we, o_mem_addr}, 96'h0);
        end else begin
          m = mem_q.pop_front();
          check("mem_access", {o_mem_we, o_mem_addr, o_mem_wdata}, m);
        end
      end
      if (o_core_ack || o_dbg_ack) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_ack", {o_core_ack, o_dbg_ack}, 96'h0);
        end else begin
          r = rsp_q.pop_front();
          act_err   = o_dbg_ack ? o_dbg_err : o_core_err;
          act_rdata = o_dbg_ack ? o_dbg_rdata : o_core_rdata;
          check("rsp", {o_core_ack, o_dbg_ack, act_err, r.rd ? act_rdata : 32'h0},
                {~r.dbg, r.dbg, r.err, r.rd ? r.rdata : 32'h0});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc;
    arstn = 1'b0;
    i_core_req = 0; i_core_we = 0; i_core_addr = 0; i_core_wdata = 0;
    i_dbg_req  = 0; i_dbg_we  = 0; i_dbg_addr  = 0; i_dbg_wdata  = 0;
    ready_dly = 0; rv_dly = -1; rv_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", {o_core_ack, o_core_err, o_core_rdata, o_dbg_ack, o_dbg_err, o_dbg_rdata}, 96'h0);
    check("reset_mem", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, 96'h0);
    @(negedge clk) arstn = 1'b1;
    @(posedge clk); #1;

    // Core read of 0x100: ready at once, rvalid two cycles later.
    ready_dly = 0; rv_dly = 2; rv_data = 32'hDEAD_BEEF;
    exp_mem(1'b0, 32'h100, 32'h0);
    exp_rsp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 32'h100, 32'h0);
    wait_acks("core_read", 1, 5, rc);
    @(posedge clk); #1;

    // Minimum-latency write and read.
    ready_dly = 0; rv_dly = -1;
    exp_mem(1'b1, 32'h20, 32'hA5A5_0001);
    exp_rsp(1'b0, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 1'b1, 32'h20, 32'hA5A5_0001);
    wait_acks("core_write_fast", 1, 3, rc);
    @(posedge clk); #1;
    ready_dly = 0; rv_dly = 1; rv_data = 32'h1234_5678;
    exp_mem(1'b0, 32'h24, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    issue(1'b1, 1'b0, 32'h24, 32'h0);
    wait_acks("dbg_read_fast", 1, 4, rc);
    @(posedge clk); #1;

    // Simultaneous held requests: grants alternate core, dbg, core.
    ready_dly = 0; rv_dly = -1;
    exp_mem(1'b1, 32'h4, 32'h11); exp_mem(1'b1, 32'h8, 32'h22); exp_mem(1'b1, 32'h4, 32'h11);
    exp_rsp(1'b0, 1'b0, 1'b0, 32'h0); exp_rsp(1'b1, 1'b0, 1'b0, 32'h0); exp_rsp(1'b0, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 1'b1, 32'h4, 32'h11);
    issue(1'b1, 1'b1, 32'h8, 32'h22);
    wait_acks("round_robin", 3, 9, rc);
    @(posedge clk); #1;

    // dbg read never accepted: timeout error, core rdata untouched.
    ready_dly = -1; rv_dly = -1;
    exp_rsp(1'b1, 1'b1, 1'b1, 32'h0);
    issue(1'b1, 1'b0, 32'h30, 32'h0);
    wait_acks("dbg_timeout", 1, TMO + 2, rc);
    check("timeout_req_cycles", 96'(rc), 96'(TMO));
    check("core_rdata_held", o_core_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // rvalid in the expiry cycle wins over the timeout.
    ready_dly = 0; rv_dly = TMO - 1; rv_data = 32'hCAFE_F00D;
    exp_mem(1'b0, 32'h40, 32'h0);
    exp_rsp(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    issue(1'b0, 1'b0, 32'h40, 32'h0);
    wait_acks("rvalid_at_expiry", 1, TMO + 2, rc);
    @(posedge clk); #1;

    // rvalid one cycle too late: error, and the late rvalid is ignored.
    ready_dly = 0; rv_dly = TMO; rv_data = 32'h55AA_55AA;
    exp_mem(1'b0, 32'h44, 32'h0);
    exp_rsp(1'b1, 1'b1, 1'b1, 32'h0);
    issue(1'b1, 1'b0, 32'h44, 32'h0);
    wait_acks("rvalid_late", 1, TMO + 2, rc);
    @(posedge clk); #1;

    // ready in the expiry cycle wins over the timeout.
    ready_dly = TMO - 1; rv_dly = -1;
    exp_mem(1'b1, 32'h48, 32'h77);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h0);
    issue(1'b1, 1'b1, 32'h48, 32'h77);
    wait_acks("ready_at_expiry", 1, TMO + 2, rc);
    check("ready_expiry_req_cycles", 96'(rc), 96'(TMO));
    @(posedge clk); #1;

    // Memory-side signals hold while requester inputs toggle during REQ.
    ready_dly = 3; rv_dly = -1;
    exp_mem(1'b1, 32'h50, 32'h600D);
    exp_rsp(1'b0, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 1'b1, 32'h50, 32'h600D);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      i_core_we    = ~i_core_we;
      i_core_addr  = i_core_addr ^ 32'hFFFF_0000;
      i_core_wdata = i_core_wdata + 32'h1;
      @(negedge clk);
      check("req_hold", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, {1'b1, 1'b1, 32'h50, 32'h600D});
    end
    wait_acks("ack_after_ready", 1, 1, rc);
    @(posedge clk); #1;

    // Reset while waiting for rvalid: abandoned, no stale ack, pointer back to dbg.
    ready_dly = 0; rv_dly = -1;
    exp_mem(1'b0, 32'h80, 32'h0);
    issue(1'b0, 1'b0, 32'h80, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    arstn = 1'b0;
    i_core_req = 1'b0;
    #1;
    check("rst_wait_resp", {o_core_ack, o_core_err, o_core_rdata, o_dbg_ack, o_dbg_err, o_dbg_rdata}, 96'h0);
    check("rst_wait_mem", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, 96'h0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    exp_mem(1'b1, 32'hC0, 32'h33); exp_mem(1'b1, 32'hC4, 32'h44);
    exp_rsp(1'b0, 1'b0, 1'b0, 32'h0); exp_rsp(1'b1, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 1'b1, 32'hC0, 32'h33);
    issue(1'b1, 1'b1, 32'hC4, 32'h44);
    wait_acks("after_reset", 2, 6, rc);

    repeat (3) @(posedge clk);
    #1;
    check("mem_q_drained", 96'(mem_q.size()), 96'h0);
    check("rsp_q_drained", 96'(rsp_q.size()), 96'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
